cnn_conv_sequencer: RTL and testbench

- Control stage directly downstream of the CNN IP register set.
- Consumes CMD_START and the MODE_* configuration fields.
- Walks every (kernel, output row, output column) position of one convolution layer and issues one operation descriptor per position to the compute datapath over a valid/ready handshake.
- Returns CMD_DONE / CMD_DONE_VALID, which the register set records in its status register.

---
 rtl/cnn_conv_sequencer_if.sv | 25 ++
 rtl/cnn_conv_sequencer.sv | 178 +++++++++++++++++
 tb/tb_cnn_conv_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/cnn_conv_sequencer_if.sv
// Descriptor handshake between the convolution sequencer (master) and the compute datapath (slave).
// CW is the width of the signed input-coordinate fields and must match the sequencer's CW.
interface cnn_conv_sequencer_if #(
  parameter int CW = 10
);
  logic                 op_valid;
  logic                 op_ready;
  logic [7:0]           op_k;
  logic [7:0]           op_ox;
  logic [7:0]           op_oy;
  logic signed [CW-1:0] op_ix;
  logic signed [CW-1:0] op_iy;
  logic                 op_first;
  logic                 op_last;

  modport master (
    output op_valid, op_k, op_ox, op_oy, op_ix, op_iy, op_first, op_last,
    input  op_ready
  );

  modport slave (
    input  op_valid, op_k, op_ox, op_oy, op_ix, op_iy, op_first, op_last,
    output op_ready
  );
endinterface

// File: rtl/cnn_conv_sequencer.sv
// Walks every (kernel, output row, output column) position of one convolution layer and
// issues one descriptor per position; reports completion or a configuration error.
module cnn_conv_sequencer #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int CW    = 10
) (
  input  logic                 clk_a,
  input  logic                 arstz_aq,
  input  logic                 CMD_START,
  input  logic [7:0]           MODE_KERNEL_SIZE,
  input  logic [7:0]           MODE_KERNEL_NUMS,
  input  logic [1:0]           MODE_STRIDE,
  input  logic                 MODE_PADDING,
  output logic                 CMD_DONE,
  output logic                 CMD_DONE_VALID,
  output logic                 busy,
  cnn_conv_sequencer_if.master opIf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } SeqState;

  localparam logic signed [CW-1:0] L_IMG_W = CW'(IMG_W);
  localparam logic signed [CW-1:0] L_IMG_H = CW'(IMG_H);

  SeqState r_state;
  SeqState w_stateNext;

  logic                 r_startPrev;
  logic [7:0]           r_K;
  logic [7:0]           r_N;
  logic [7:0]           r_P;
  logic [1:0]           r_S;
  logic [7:0]           r_k;
  logic [7:0]           r_ox;
  logic [7:0]           r_oy;
  logic signed [CW-1:0] r_ix;
  logic signed [CW-1:0] r_iy;
  logic                 r_done;

  logic                 w_start;
  logic                 w_valid;
  logic                 w_rowWrap;
  logic                 w_kernWrap;
  logic                 w_last;
  logic                 w_cfgErr;
  logic signed [CW-1:0] w_kS;
  logic signed [CW-1:0] w_sS;
  logic signed [CW-1:0] w_pS;
  logic signed [CW-1:0] w_ixStep;
  logic signed [CW-1:0] w_iyStep;

  assign w_start = CMD_START & ~r_startPrev;

  assign w_kS = {{(CW-8){1'b0}}, r_K};
  assign w_sS = {{(CW-2){1'b0}}, r_S};
  assign w_pS = {{(CW-8){1'b0}}, r_P};

  // A window placed one stride further would cross the padded edge: wrap instead of stepping.
  assign w_ixStep   = r_ix + w_sS;
  assign w_iyStep   = r_iy + w_sS;
  assign w_rowWrap  = (w_ixStep + w_kS) > (L_IMG_W + w_pS);
  assign w_kernWrap = (w_iyStep + w_kS) > (L_IMG_H + w_pS);
  assign w_last     = (r_k == r_N - 8'd1) & w_rowWrap & w_kernWrap;

  assign w_cfgErr = (r_K == 8'd0) | (r_N == 8'd0) | (r_S == 2'd0) |
                    (w_kS > L_IMG_W + w_pS + w_pS) |
                    (w_kS > L_IMG_H + w_pS + w_pS);

  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_valid     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_stateNext = CHECK;
        end
      end
      CHECK: begin
        w_stateNext = w_cfgErr ? DONE : RUN;
      end
      RUN: begin
        w_valid = 1'b1;
        if (opIf.op_ready && w_last) begin
          w_stateNext = DONE;
        end
      end
      DONE: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) begin
      r_startPrev <= 1'b0;
      r_K         <= 8'd0;
      r_N         <= 8'd0;
      r_P         <= 8'd0;
      r_S         <= 2'd0;
      r_k         <= 8'd0;
      r_ox        <= 8'd0;
      r_oy        <= 8'd0;
      r_ix        <= '0;
      r_iy        <= '0;
      r_done      <= 1'b0;
    end else begin
      r_startPrev <= CMD_START;
      if (r_state == IDLE && w_start) begin
        r_K <= MODE_KERNEL_SIZE;
        r_N <= MODE_KERNEL_NUMS;
        r_S <= MODE_STRIDE;
        r_P <= MODE_PADDING ? ((MODE_KERNEL_SIZE - 8'd1) >> 1) : 8'd0;
      end
      if (r_state == CHECK) begin
        r_k  <= 8'd0;
        r_ox <= 8'd0;
        r_oy <= 8'd0;
        r_ix <= -w_pS;
        r_iy <= -w_pS;
        if (w_cfgErr) begin
          r_done <= 1'b0;
        end
      end
      // Counters only move on an accepted descriptor, so back-pressure holds the payload.
      if (r_state == RUN && opIf.op_ready) begin
        if (w_rowWrap) begin
          r_ox <= 8'd0;
          r_ix <= -w_pS;
          if (w_kernWrap) begin
            r_oy <= 8'd0;
            r_iy <= -w_pS;
            r_k  <= r_k + 8'd1;
          end else begin
            r_oy <= r_oy + 8'd1;
            r_iy <= w_iyStep;
          end
        end else begin
          r_ox <= r_ox + 8'd1;
          r_ix <= w_ixStep;
        end
        if (w_last) begin
          r_done <= 1'b1;
        end
      end
    end
  end

  assign opIf.op_valid = w_valid;
  assign opIf.op_k     = r_k;
  assign opIf.op_ox    = r_ox;
  assign opIf.op_oy    = r_oy;
  assign opIf.op_ix    = r_ix;
  assign opIf.op_iy    = r_iy;
  assign opIf.op_first = w_valid & (r_ox == 8'd0) & (r_oy == 8'd0);
  assign opIf.op_last  = w_valid & w_last;

  assign CMD_DONE       = r_done;
  assign CMD_DONE_VALID = (r_state == DONE);
  assign busy           = (r_state != IDLE);

endmodule

// File: tb/tb_cnn_conv_sequencer.sv
// Directed bench for cnn_conv_sequencer: reference-loop scoreboard per layer, config errors,
// start-edge rules, mid-layer disturbance and reset during RUN.
module tb_cnn_conv_sequencer;
  localparam int CW  = 10;
  localparam int IMG = 32;

  logic       clk_a = 1'b0;
  logic       arstz_aq;
  logic       CMD_START;
  logic [7:0] MODE_KERNEL_SIZE;
  logic [7:0] MODE_KERNEL_NUMS;
  logic [1:0] MODE_STRIDE;
  logic       MODE_PADDING;
  logic       CMD_DONE;
  logic       CMD_DONE_VALID;
  logic       busy;

  int vectorCount = 0;
  int missCount   = 0;

  cnn_conv_sequencer_if #(.CW(CW)) opIf ();

  cnn_conv_sequencer #(.IMG_W(IMG), .IMG_H(IMG), .CW(CW)) dut (
    .clk_a            (clk_a),
    .arstz_aq         (arstz_aq),
    .CMD_START        (CMD_START),
    .MODE_KERNEL_SIZE (MODE_KERNEL_SIZE),
    .MODE_KERNEL_NUMS (MODE_KERNEL_NUMS),
    .MODE_STRIDE      (MODE_STRIDE),
    .MODE_PADDING     (MODE_PADDING),
    .CMD_DONE         (CMD_DONE),
    .CMD_DONE_VALID   (CMD_DONE_VALID),
    .busy             (busy),
    .opIf             (opIf)
  );

  always #5 clk_a = ~clk_a;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] packDesc(input logic v, input logic [7:0] k, input logic [7:0] ox,
                                           input logic [7:0] oy, input logic [CW-1:0] ix,
                                           input logic [CW-1:0] iy, input logic f, input logic l);
    return {17'd0, v, k, ox, oy, ix, iy, f, l};
  endfunction

  function automatic logic [63:0] observedDesc();
    return packDesc(opIf.op_valid, opIf.op_k, opIf.op_ox, opIf.op_oy, opIf.op_ix, opIf.op_iy,
                    opIf.op_first, opIf.op_last);
  endfunction

  // Drops the start level for a cycle, sets the mode and raises start at a falling edge.
  task automatic applyStimulus(input int k, input int n, input int s, input bit pad);
    @(negedge clk_a);
    CMD_START        = 1'b0;
    MODE_KERNEL_SIZE = 8'(k);
    MODE_KERNEL_NUMS = 8'(n);
    MODE_STRIDE      = 2'(s);
    MODE_PADDING     = pad;
    @(negedge clk_a);
    CMD_START = 1'b1;
  endtask

  task automatic runLayer(input string tag, input int k, input int n, input int s, input bit pad,
                          input int readyPct, input bit disturb);
    logic [63:0]   expQ[$];
    logic [63:0]   obs;
    logic [63:0]   held;
    logic [CW-1:0] eix;
    logic [CW-1:0] eiy;
    int            p, ow, oh, got, firstCount, lastCount;
    bit            stalled, doneSeen, anyBusy;

    p  = pad ? (k - 1) / 2 : 0;
    ow = (IMG + 2 * p - k) / s + 1;
    oh = (IMG + 2 * p - k) / s + 1;
    for (int kk = 0; kk < n; kk++)
      for (int oy = 0; oy < oh; oy++)
        for (int ox = 0; ox < ow; ox++) begin
          eix = CW'(ox * s - p);
          eiy = CW'(oy * s - p);
          expQ.push_back(packDesc(1'b1, 8'(kk), 8'(ox), 8'(oy), eix, eiy, (ox == 0 && oy == 0),
                                  (kk == n - 1 && oy == oh - 1 && ox == ow - 1)));
        end

    applyStimulus(k, n, s, pad);
    got = 0; firstCount = 0; lastCount = 0;
    stalled = 1'b0; doneSeen = 1'b0; held = '0;
    for (int cyc = 0; cyc < 20000 && !doneSeen; cyc++) begin
      @(negedge clk_a);
      if (disturb) begin
        if (cyc == 40) CMD_START = 1'b0;
        if (cyc == 45) CMD_START = 1'b1;
        if (cyc == 50) begin
          MODE_KERNEL_SIZE = 8'd5;
          MODE_KERNEL_NUMS = 8'd3;
          MODE_STRIDE      = 2'd3;
          MODE_PADDING     = 1'b0;
        end
      end
      obs = observedDesc();
      if (stalled) checkOutput({tag, " stall hold"}, obs, held);
      opIf.op_ready = ($urandom_range(0, 99) < readyPct);
      if (opIf.op_valid && opIf.op_ready) begin
        if (expQ.size() == 0) checkOutput({tag, " extra desc"}, 64'd1, 64'd0);
        else checkOutput({tag, " desc"}, obs, expQ.pop_front());
        got++;
        firstCount += int'(opIf.op_first);
        lastCount  += int'(opIf.op_last);
      end
      stalled = opIf.op_valid && !opIf.op_ready;
      held    = obs;
      if (CMD_DONE_VALID) begin
        doneSeen = 1'b1;
        checkOutput({tag, " done flag"}, 64'(CMD_DONE), 64'd1);
      end
    end
    checkOutput({tag, " done seen"}, 64'(doneSeen), 64'd1);
    checkOutput({tag, " desc count"}, 64'(got), 64'(n * ow * oh));
    checkOutput({tag, " first count"}, 64'(firstCount), 64'(n));
    checkOutput({tag, " last count"}, 64'(lastCount), 64'd1);
    // Start is still high here, so the sequencer must stay idle.
    anyBusy = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk_a);
      if (busy || CMD_DONE_VALID) anyBusy = 1'b1;
    end
    checkOutput({tag, " idle after"}, 64'(anyBusy), 64'd0);
    opIf.op_ready = 1'b0;
  endtask

  task automatic errorCase(input string tag, input int k, input int n, input int s);
    bit anyValid;
    int doneAt;
    anyValid = 1'b0;
    doneAt   = -1;
    applyStimulus(k, n, s, 1'b0);
    opIf.op_ready = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk_a);
      if (opIf.op_valid) anyValid = 1'b1;
      if (CMD_DONE_VALID && doneAt < 0) begin
        doneAt = cyc;
        checkOutput({tag, " done flag"}, 64'(CMD_DONE), 64'd0);
      end
    end
    checkOutput({tag, " no op_valid"}, 64'(anyValid), 64'd0);
    checkOutput({tag, " done cycle"}, 64'(doneAt), 64'd2);
    opIf.op_ready = 1'b0;
  endtask

  initial begin
    arstz_aq         = 1'b0;
    CMD_START        = 1'b0;
    MODE_KERNEL_SIZE = 8'd0;
    MODE_KERNEL_NUMS = 8'd0;
    MODE_STRIDE      = 2'd0;
    MODE_PADDING     = 1'b0;
    opIf.op_ready    = 1'b0;
    repeat (3) @(negedge clk_a);
    checkOutput("reset payload", observedDesc(), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(CMD_DONE), 64'd0);
    checkOutput("reset done valid", 64'(CMD_DONE_VALID), 64'd0);
    arstz_aq = 1'b1;

    runLayer("k3n2s1p0", 3, 2, 1, 1'b0, 100, 1'b0);
    runLayer("k3n1s2p1", 3, 1, 2, 1'b1, 100, 1'b0);
    errorCase("err k0", 0, 1, 1);
    errorCase("err n0", 3, 0, 1);
    errorCase("err k40", 40, 1, 1);
    runLayer("k5n1s3 bp", 5, 1, 3, 1'b0, 30, 1'b0);
    runLayer("disturb", 3, 1, 2, 1'b1, 60, 1'b1);

    // Reset in the middle of the second kernel, then a fresh layer must begin at k=0.
    applyStimulus(3, 2, 1, 1'b0);
    opIf.op_ready = 1'b1;
    repeat (1000) @(negedge clk_a);
    checkOutput("pre-reset busy", 64'(busy), 64'd1);
    checkOutput("pre-reset kernel", 64'(opIf.op_k), 64'd1);
    #1;
    arstz_aq  = 1'b0;
    CMD_START = 1'b0;
    #1;
    checkOutput("mid reset valid", 64'(opIf.op_valid), 64'd0);
    checkOutput("mid reset busy", 64'(busy), 64'd0);
    checkOutput("mid reset done valid", 64'(CMD_DONE_VALID), 64'd0);
    opIf.op_ready = 1'b0;
    @(negedge clk_a);
    arstz_aq = 1'b1;
    runLayer("restart", 3, 2, 1, 1'b0, 100, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end
endmodule
